// File: rtl/bicubic_refpx_block_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_pkg
// Description : Shared types and constants for the bicubic reference-pixel
//               block feeder (mux codes, FSM states, row position classes).
// Revision    : 1.0 - initial release
// ============================================================================
package bicubic_pkg;

  // Column-padding select codes for the 4x4 block buffer
  localparam logic [3:0] MUX_NORMAL = 4'b0000;
  localparam logic [3:0] MUX_PAD_L  = 4'b0001;
  localparam logic [3:0] MUX_PAD_R1 = 4'b0100;
  localparam logic [3:0] MUX_PAD_R2 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WIN      = 2'd2,
    LINE_END = 2'd3
  } feeder_state_t;

  // Vertical position class of the current output row
  typedef enum logic [1:0] {
    YCLS_TOP    = 2'd0,
    YCLS_NORMAL = 2'd1,
    YCLS_HM2    = 2'd2,
    YCLS_HM1    = 2'd3
  } ycls_t;

endpackage
`default_nettype wire

// File: rtl/bicubic_refpx_block_feeder_row_clamp.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_row_clamp
// Description : Combinational vertical clamp of a 4-row source column.
//               Rows outside the image are replaced by the nearest edge row.
// Revision    : 1.0 - initial release
// ============================================================================
module bicubic_row_clamp
  import bicubic_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  ycls_t                  ycls,
  input  logic [PIXEL_WIDTH-1:0] in_0,
  input  logic [PIXEL_WIDTH-1:0] in_1,
  input  logic [PIXEL_WIDTH-1:0] in_2,
  input  logic [PIXEL_WIDTH-1:0] in_3,
  output logic [PIXEL_WIDTH-1:0] out_0,
  output logic [PIXEL_WIDTH-1:0] out_1,
  output logic [PIXEL_WIDTH-1:0] out_2,
  output logic [PIXEL_WIDTH-1:0] out_3
);

  // Replace out-of-image rows (y-1 at top, y+1/y+2 at bottom) with edge rows
  always_comb begin
    out_0 = in_0;
    out_1 = in_1;
    out_2 = in_2;
    out_3 = in_3;
    case (ycls)
      YCLS_TOP: out_0 = in_1;
      YCLS_HM2: out_3 = in_2;
      YCLS_HM1: begin
        out_2 = in_1;
        out_3 = in_1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bicubic_refpx_block_feeder.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_refpx_block_feeder
// Description : Write-side sequencer for the 4x4 reference-pixel block
//               buffer. Consumes a 4-row column stream, writes clamped
//               columns into the buffer and hands one window per output
//               pixel to the interpolation core.
// Revision    : 1.0 - initial release
// ============================================================================
module bicubic_refpx_block_feeder
  import bicubic_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   cfg_width,
  input  logic [DIM_WIDTH-1:0]   cfg_height,
  input  logic [PIXEL_WIDTH-1:0] s_px_0,
  input  logic [PIXEL_WIDTH-1:0] s_px_1,
  input  logic [PIXEL_WIDTH-1:0] s_px_2,
  input  logic [PIXEL_WIDTH-1:0] s_px_3,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [PIXEL_WIDTH-1:0] buf_line_0,
  output logic [PIXEL_WIDTH-1:0] buf_line_1,
  output logic [PIXEL_WIDTH-1:0] buf_line_2,
  output logic [PIXEL_WIDTH-1:0] buf_line_3,
  output logic                   buf_wren,
  output logic                   buf_clken,
  output logic [3:0]             buf_mux_ctrl,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [DIM_WIDTH-1:0]   win_x,
  output logic [DIM_WIDTH-1:0]   win_y,
  output logic                   frame_done
);

  feeder_state_t          state, state_nxt;
  logic [DIM_WIDTH-1:0]   width, height, x, y;
  logic [DIM_WIDTH-1:0]   w_m1, w_m2, w_m4, h_m1, h_m2;
  logic [1:0]             fill_cnt;
  logic [PIXEL_WIDTH-1:0] held_0, held_1, held_2, held_3;
  logic [PIXEL_WIDTH-1:0] clamp_0, clamp_1, clamp_2, clamp_3;
  ycls_t                  ycls;
  logic                   beat;
  logic                   dummy;

  assign w_m1 = width  - DIM_WIDTH'(1);
  assign w_m2 = width  - DIM_WIDTH'(2);
  assign w_m4 = width  - DIM_WIDTH'(4);
  assign h_m1 = height - DIM_WIDTH'(1);
  assign h_m2 = height - DIM_WIDTH'(2);

  // Classify the current row for the vertical clamp
  always_comb begin
    ycls = YCLS_NORMAL;
    if (y == '0)        ycls = YCLS_TOP;
    else if (y == h_m2) ycls = YCLS_HM2;
    else if (y == h_m1) ycls = YCLS_HM1;
  end

  bicubic_row_clamp #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_row_clamp (
    .ycls  (ycls),
    .in_0  (s_px_0),
    .in_1  (s_px_1),
    .in_2  (s_px_2),
    .in_3  (s_px_3),
    .out_0 (clamp_0),
    .out_1 (clamp_1),
    .out_2 (clamp_2),
    .out_3 (clamp_3)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake: the input is fetched while filling and when a
  // window with a real column still to the right is accepted; the last two
  // advances of a row re-write the held column instead
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    dummy     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (fill_cnt == 2'd2)) state_nxt = WIN;
      end
      WIN: begin
        if (win_ready) begin
          if (x <= w_m4) begin
            s_ready = 1'b1;
            if (!s_valid) state_nxt = FILL;
          end else if (x != w_m1) begin
            dummy = 1'b1;
          end else begin
            state_nxt = (y < h_m1) ? LINE_END : IDLE;
          end
        end
      end
      LINE_END: begin
        state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat       = s_valid && s_ready;
  assign buf_wren   = beat || dummy;
  assign buf_clken  = 1'b1;
  assign win_valid  = (state == WIN);
  assign win_x      = x;
  assign win_y      = y;
  assign buf_line_0 = beat ? clamp_0 : held_0;
  assign buf_line_1 = beat ? clamp_1 : held_1;
  assign buf_line_2 = beat ? clamp_2 : held_2;
  assign buf_line_3 = beat ? clamp_3 : held_3;

  // Column-padding select for the presented window
  always_comb begin
    buf_mux_ctrl = MUX_NORMAL;
    if (state == WIN) begin
      if (x == '0)        buf_mux_ctrl = MUX_PAD_L;
      else if (x == w_m2) buf_mux_ctrl = MUX_PAD_R1;
      else if (x == w_m1) buf_mux_ctrl = MUX_PAD_R2;
    end
  end

  // Frame geometry, coordinates, fill counter, held column and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      width      <= '0;
      height     <= '0;
      x          <= '0;
      y          <= '0;
      fill_cnt   <= 2'd0;
      held_0     <= '0;
      held_1     <= '0;
      held_2     <= '0;
      held_3     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (beat) begin
        held_0 <= clamp_0;
        held_1 <= clamp_1;
        held_2 <= clamp_2;
        held_3 <= clamp_3;
      end
      case (state)
        IDLE: begin
          if (start) begin
            width    <= cfg_width;
            height   <= cfg_height;
            x        <= '0;
            y        <= '0;
            fill_cnt <= 2'd0;
          end
        end
        FILL: begin
          if (beat) fill_cnt <= (fill_cnt == 2'd2) ? 2'd0 : fill_cnt + 2'd1;
        end
        WIN: begin
          if (win_ready) begin
            if (x != w_m1) x <= x + DIM_WIDTH'(1);
            // A starved fetch re-enters FILL needing just the one column
            if ((x <= w_m4) && !s_valid) fill_cnt <= 2'd2;
            if ((x == w_m1) && (y == h_m1)) frame_done <= 1'b1;
          end
        end
        LINE_END: begin
          x        <= '0;
          y        <= y + DIM_WIDTH'(1);
          fill_cnt <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bicubic_refpx_block_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bicubic_refpx_block_feeder
// Description : Self-checking bench for bicubic_refpx_block_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bicubic_refpx_block_feeder;

  localparam int PW = 8;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] cfg_width, cfg_height;
  logic [PW-1:0] s_px_0, s_px_1, s_px_2, s_px_3;
  logic          s_valid, s_ready;
  logic [PW-1:0] buf_line_0, buf_line_1, buf_line_2, buf_line_3;
  logic          buf_wren, buf_clken;
  logic [3:0]    buf_mux_ctrl;
  logic          win_valid, win_ready;
  logic [DW-1:0] win_x, win_y;
  logic          frame_done;

  always #5 clk = ~clk;

  bicubic_refpx_block_feeder #(.PIXEL_WIDTH(PW), .DIM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_px_0(s_px_0), .s_px_1(s_px_1), .s_px_2(s_px_2), .s_px_3(s_px_3),
    .s_valid(s_valid), .s_ready(s_ready),
    .buf_line_0(buf_line_0), .buf_line_1(buf_line_1),
    .buf_line_2(buf_line_2), .buf_line_3(buf_line_3),
    .buf_wren(buf_wren), .buf_clken(buf_clken), .buf_mux_ctrl(buf_mux_ctrl),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Source image model: 0 = column pattern c*16+k, 1 = constant vector, 2 = image
  int         src_mode   = 0;
  logic [7:0] cv [4];
  logic [7:0] img [16][16];
  int         src_w = 4, src_h = 4;
  int         valid_mode = 0;   // 0 always, 1 random, 2 gated by src_hold
  bit         src_hold   = 1'b0;
  int         ready_mode = 0;   // 0 always, 1 random, 2 ready_val
  bit         ready_val  = 1'b1;
  int         restart_req = 0;
  int         clr_req     = 0;

  // Beat vector presented for output row y, column c (rows y-1..y+2)
  function automatic logic [7:0] src_px(int k, int y, int c);
    int r;
    r = y - 1 + k;
    if (src_mode == 0) return 8'(c * 16 + k);
    if (src_mode == 1) return cv[k];
    if (r < 0 || r >= src_h) return 8'(8'hA5 ^ (c * 3 + k));
    return img[r][c];
  endfunction

  // Reference: buffer line k holds source row clamp(y-1+k) into [0, H-1]
  function automatic logic [7:0] exp_line(int k, int y, int c, int h);
    int r;
    r = y - 1 + k;
    if (r < 0)     r = 0;
    if (r > h - 1) r = h - 1;
    return src_px(r - (y - 1), y, c);
  endfunction

  function automatic logic [31:0] exp_col(int y, int c, int h);
    return {exp_line(3, y, c, h), exp_line(2, y, c, h),
            exp_line(1, y, c, h), exp_line(0, y, c, h)};
  endfunction

  function automatic logic [3:0] exp_mux(int x, int w);
    if (x == 0)     return 4'b0001;
    if (x == w - 2) return 4'b0100;
    if (x == w - 1) return 4'b1000;
    return 4'b0000;
  endfunction

  // Source / sink driver: advances the column after each accepted beat
  initial begin
    bit took;
    int col, row, ack;
    col = 0; row = 0; ack = 0;
    s_valid = 1'b0; win_ready = 1'b0;
    s_px_0 = '0; s_px_1 = '0; s_px_2 = '0; s_px_3 = '0;
    forever begin
      @(negedge clk);
      took = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (restart_req != ack) begin
        ack = restart_req; col = 0; row = 0;
      end else if (took) begin
        col++;
        if (col == src_w) begin col = 0; row++; end
      end
      case (valid_mode)
        0:       s_valid = 1'b1;
        1:       s_valid = ($urandom_range(0, 3) != 0);
        default: s_valid = !src_hold;
      endcase
      s_px_0 = src_px(0, row, col);
      s_px_1 = src_px(1, row, col);
      s_px_2 = src_px(2, row, col);
      s_px_3 = src_px(3, row, col);
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ($urandom_range(0, 2) != 0);
        default: win_ready = ready_val;
      endcase
    end
  end

  // Monitor: records writes, accepted windows and events with cycle stamps
  logic [31:0] wq[$];
  int          wstamp[$];
  logic [27:0] winq[$];
  int          winstamp[$];
  int          n_beats, n_done, n_viol, cyc;
  initial begin
    int ack;
    ack = 0; cyc = 0; n_beats = 0; n_done = 0; n_viol = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_req != ack) begin
        ack = clr_req;
        wq.delete(); wstamp.delete(); winq.delete(); winstamp.delete();
        n_beats = 0; n_done = 0; n_viol = 0;
      end
      if (!rst) begin
        if (buf_wren) begin
          wq.push_back({buf_line_3, buf_line_2, buf_line_1, buf_line_0});
          wstamp.push_back(cyc);
        end
        if (win_valid && win_ready) begin
          winq.push_back({win_y, win_x, buf_mux_ctrl});
          winstamp.push_back(cyc);
        end
        if (s_valid && s_ready) n_beats++;
        if (frame_done) n_done++;
        if (buf_wren && win_valid && !win_ready) n_viol++;
      end
    end
  end

  task automatic do_start(input int w, input int h);
    @(negedge clk);
    src_w = w; src_h = h;
    restart_req++; clr_req++;
    cfg_width = DW'(w); cfg_height = DW'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_win(input int wx, input int wy, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (win_valid && win_x == DW'(wx) && win_y == DW'(wy)) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s: window (%0d,%0d) not seen within 400 cycles", tag, wx, wy);
    else n_pass++;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s: frame_done not seen within 4000 cycles", tag);
    else n_pass++;
    @(negedge clk);
  endtask

  // Scoreboard comparison of one recorded frame against the reference
  task automatic score_frame(input int w, input int h, input bit full_rate, input string tag);
    int idx, c, b;
    n_checks++;
    if (wq.size() != (w + 2) * h)
      $display("FAIL %s write_count: got %0d expected %0d", tag, wq.size(), (w + 2) * h);
    else begin
      n_pass++;
      idx = 0;
      for (int y = 0; y < h; y++)
        for (int j = 0; j < w + 2; j++) begin
          c = (j < w) ? j : w - 1;
          n_checks++;
          if (wq[idx] !== exp_col(y, c, h))
            $display("FAIL %s write y=%0d j=%0d: got %h expected %h", tag, y, j, wq[idx], exp_col(y, c, h));
          else n_pass++;
          idx++;
        end
    end
    n_checks++;
    if (winq.size() != w * h)
      $display("FAIL %s window_count: got %0d expected %0d", tag, winq.size(), w * h);
    else begin
      n_pass++;
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          n_checks++;
          if (winq[y * w + x] !== {DW'(y), DW'(x), exp_mux(x, w)})
            $display("FAIL %s window %0d: got %h expected %h", tag, y * w + x,
                     winq[y * w + x], {DW'(y), DW'(x), exp_mux(x, w)});
          else n_pass++;
        end
    end
    n_checks++;
    if (n_done !== 1) $display("FAIL %s frame_done_pulses: got %0d expected 1", tag, n_done);
    else n_pass++;
    n_checks++;
    if (n_beats !== w * h) $display("FAIL %s beats: got %0d expected %0d", tag, n_beats, w * h);
    else n_pass++;
    n_checks++;
    if (n_viol !== 0) $display("FAIL %s write_while_window_pending: got %0d expected 0", tag, n_viol);
    else n_pass++;
    if (full_rate && wq.size() == (w + 2) * h && winq.size() == w * h) begin
      for (int y = 0; y < h; y++) begin
        b = y * (w + 2);
        n_checks++;
        if (wstamp[b + 2] - wstamp[b] !== 2 || winstamp[y * w] - wstamp[b + 2] !== 1)
          $display("FAIL %s fill_timing y=%0d: got fill span %0d, first window +%0d, expected 2 and 1",
                   tag, y, wstamp[b + 2] - wstamp[b], winstamp[y * w] - wstamp[b + 2]);
        else n_pass++;
        n_checks++;
        if (winstamp[y * w + w - 1] - winstamp[y * w] !== w - 1)
          $display("FAIL %s window_rate y=%0d: got span %0d expected %0d", tag, y,
                   winstamp[y * w + w - 1] - winstamp[y * w], w - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_ready, buf_wren, win_valid, frame_done, buf_clken} !== 5'b00001)
      $display("FAIL reset_ctrl: got %b expected 00001", {s_ready, buf_wren, win_valid, frame_done, buf_clken});
    else n_pass++;
    n_checks++;
    if ({buf_mux_ctrl, win_x, win_y} !== '0)
      $display("FAIL reset_coord: got mux=%b x=%0d y=%0d expected 0", buf_mux_ctrl, win_x, win_y);
    else n_pass++;
    n_checks++;
    if ({buf_line_3, buf_line_2, buf_line_1, buf_line_0} !== 32'h0)
      $display("FAIL reset_lines: got %h expected 0", {buf_line_3, buf_line_2, buf_line_1, buf_line_0});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_w4_pattern();
    src_mode = 0; valid_mode = 0; ready_mode = 0;
    do_start(4, 4);
    wait_done("w4_pattern");
    score_frame(4, 4, 1'b1, "w4_pattern");
    n_checks++;
    if (wq.size() < 11 || wq[9] !== 32'h33323130 || wq[10] !== 32'h33323130)
      $display("FAIL w4_dummy_writes: got %h %h expected 33323130",
               (wq.size() > 9) ? wq[9] : 32'hx, (wq.size() > 10) ? wq[10] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_clamp();
    src_mode = 1; valid_mode = 0; ready_mode = 0;
    cv[0] = 8'hAA; cv[1] = 8'h11; cv[2] = 8'h22; cv[3] = 8'h33;
    do_start(4, 4);
    wait_done("clamp_top");
    n_checks++;
    if (wq.size() < 1 || wq[0] !== 32'h33221111)
      $display("FAIL clamp_top: got %h expected 33221111", (wq.size() > 0) ? wq[0] : 32'hx);
    else n_pass++;
    score_frame(4, 4, 1'b1, "clamp_top");
    cv[0] = 8'h10; cv[1] = 8'h20; cv[2] = 8'h30; cv[3] = 8'h40;
    do_start(4, 4);
    wait_done("clamp_bottom");
    n_checks++;
    if (wq.size() < 24 || wq[18] !== 32'h20202010)
      $display("FAIL clamp_bottom_hm1: got %h expected 20202010", (wq.size() > 18) ? wq[18] : 32'hx);
    else n_pass++;
    n_checks++;
    if (wq.size() < 24 || wq[12][31:24] !== 8'h30)
      $display("FAIL clamp_bottom_hm2: got line3 %h expected 30", (wq.size() > 12) ? wq[12][31:24] : 8'hx);
    else n_pass++;
    score_frame(4, 4, 1'b1, "clamp_bottom");
  endtask

  task automatic test_ready_stall();
    src_mode = 2; valid_mode = 0; ready_mode = 2; ready_val = 1'b1;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    do_start(8, 4);
    wait_win(1, 0, "stall_reach");
    ready_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (!win_valid || win_x !== DW'(2) || buf_mux_ctrl !== 4'b0000 || buf_wren || s_ready ||
          {buf_line_3, buf_line_2, buf_line_1, buf_line_0} !== exp_col(0, 4, 4))
        $display("FAIL stall_hold %0d: got v=%b x=%0d mux=%b wren=%b rdy=%b lines=%h expected 1 2 0000 0 0 %h",
                 i, win_valid, win_x, buf_mux_ctrl, buf_wren, s_ready,
                 {buf_line_3, buf_line_2, buf_line_1, buf_line_0}, exp_col(0, 4, 4));
      else n_pass++;
    end
    ready_val = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!buf_wren || !s_ready || {buf_line_3, buf_line_2, buf_line_1, buf_line_0} !== exp_col(0, 5, 4))
      $display("FAIL stall_release: got wren=%b rdy=%b lines=%h expected 1 1 %h", buf_wren, s_ready,
               {buf_line_3, buf_line_2, buf_line_1, buf_line_0}, exp_col(0, 5, 4));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (!win_valid || win_x !== DW'(3))
      $display("FAIL stall_next: got v=%b x=%0d expected 1 3", win_valid, win_x);
    else n_pass++;
    ready_mode = 0;
    wait_done("stall");
    score_frame(8, 4, 1'b0, "stall");
  endtask

  task automatic test_valid_gap();
    src_mode = 2; valid_mode = 2; src_hold = 1'b0; ready_mode = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    do_start(8, 4);
    wait_win(0, 0, "gap_reach");
    src_hold = 1'b1;
    @(negedge clk);
    n_checks++;
    if (!win_valid || win_x !== DW'(1) || !s_ready || buf_wren)
      $display("FAIL gap_accept: got v=%b x=%0d rdy=%b wren=%b expected 1 1 1 0", win_valid, win_x, s_ready, buf_wren);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (win_valid || buf_wren || !s_ready)
        $display("FAIL gap_wait %0d: got v=%b wren=%b rdy=%b expected 0 0 1", i, win_valid, buf_wren, s_ready);
      else n_pass++;
    end
    src_hold = 1'b0;
    @(negedge clk);
    n_checks++;
    if (win_valid || !buf_wren || {buf_line_3, buf_line_2, buf_line_1, buf_line_0} !== exp_col(0, 4, 4))
      $display("FAIL gap_beat: got v=%b wren=%b lines=%h expected 0 1 %h", win_valid, buf_wren,
               {buf_line_3, buf_line_2, buf_line_1, buf_line_0}, exp_col(0, 4, 4));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (!win_valid || win_x !== DW'(2))
      $display("FAIL gap_resume: got v=%b x=%0d expected 1 2", win_valid, win_x);
    else n_pass++;
    valid_mode = 0;
    wait_done("gap");
    score_frame(8, 4, 1'b0, "gap");
  endtask

  task automatic test_reset_midframe();
    src_mode = 2; valid_mode = 0; ready_mode = 0;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    do_start(8, 4);
    wait_win(2, 1, "abort_reach");
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_ready, buf_wren, win_valid, frame_done, buf_clken} !== 5'b00001 ||
        {buf_mux_ctrl, win_x, win_y} !== '0 ||
        {buf_line_3, buf_line_2, buf_line_1, buf_line_0} !== 32'h0)
      $display("FAIL abort_reset: got ctrl=%b mux=%b x=%0d y=%0d lines=%h expected 00001 0 0 0 0",
               {s_ready, buf_wren, win_valid, frame_done, buf_clken}, buf_mux_ctrl, win_x, win_y,
               {buf_line_3, buf_line_2, buf_line_1, buf_line_0});
    else n_pass++;
    rst = 1'b0;
    do_start(8, 4);
    wait_done("abort_restart");
    score_frame(8, 4, 1'b1, "abort_restart");
  endtask

  task automatic test_start_in_win();
    src_mode = 0; valid_mode = 0; ready_mode = 0;
    do_start(4, 4);
    wait_win(0, 0, "start_in_win_reach");
    cfg_width = DW'(8); cfg_height = DW'(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_in_win");
    score_frame(4, 4, 1'b1, "start_in_win");
  endtask

  task automatic test_random();
    int w, h;
    src_mode = 2; valid_mode = 1; ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      w = $urandom_range(4, 12);
      h = $urandom_range(4, 8);
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
      do_start(w, h);
      wait_done("random");
      score_frame(w, h, 1'b0, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_width = DW'(4); cfg_height = DW'(4);
    test_reset();
    test_w4_pattern();
    test_clamp();
    test_ready_stall();
    test_valid_gap();
    test_reset_midframe();
    test_start_in_win();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
